// File: rtl/reg_bus_ctrl_if.sv
// Signal bundle between datapath control, reg_bus_ctrl and the shared 16-bit register bus.
// Optional xfer_count member exists only when XFER_COUNT_EN is defined.
interface reg_bus_ctrl_if #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned IDX_W = 3
);

  logic             req;
  logic             imm_sel;
  logic [IDX_W-1:0] src;
  logic [IDX_W-1:0] dst;
  logic [15:0]      imm;
  logic             ready;
  logic             done;
  logic             err;
  logic [NREG-1:0]  read_en;
  logic [NREG-1:0]  write_en;
  logic             bus_oe;
  logic [15:0]      bus_out;
  logic [15:0]      bus_in;
  logic [15:0]      data_out;
`ifdef XFER_COUNT_EN
  logic [15:0]      xfer_count;
`endif

  // Controller side: initiates register-bus strobes.
  modport master (
    input  req, imm_sel, src, dst, imm, bus_in,
`ifdef XFER_COUNT_EN
    output xfer_count,
`endif
    output ready, done, err, read_en, write_en, bus_oe, bus_out, data_out
  );

  // Requester and register-bank side.
  modport slave (
    output req, imm_sel, src, dst, imm, bus_in,
`ifdef XFER_COUNT_EN
    input  xfer_count,
`endif
    input  ready, done, err, read_en, write_en, bus_oe, bus_out, data_out
  );

endinterface

// File: rtl/reg_bus_ctrl.sv
// Shared register-bus initiator: one word per request, register->register or immediate->register.
// Define XFER_COUNT_EN to add a saturating completed-transfer counter (xfer_count).
module reg_bus_ctrl #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  reg_bus_ctrl_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  // Bit i set when index i addresses an existing register; covers every encodable index.
  localparam int unsigned     NIdx     = 2 ** IDX_W;
  localparam logic [NIdx-1:0] IdxValid = NIdx'((64'd1 << NREG) - 64'd1);

  logic [2:0]       state_q, state_d;
  logic             imm_sel_q, imm_sel_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic [15:0]      imm_q, imm_d;
  logic [15:0]      data_out_q, data_out_d;

  logic             dst_bad;
  logic             src_bad;
  logic             is_noop;
  logic             src_drive;
  logic [NREG-1:0]  read_en;
  logic [NREG-1:0]  write_en;
  logic             bus_oe;

  assign dst_bad = !IdxValid[bus.dst];
  assign src_bad = !bus.imm_sel && !IdxValid[bus.src];
  assign is_noop = !bus.imm_sel && (bus.src == bus.dst);

  always_comb begin
    state_d    = state_q;
    imm_sel_d  = imm_sel_q;
    src_d      = src_q;
    dst_d      = dst_q;
    imm_d      = imm_q;
    data_out_d = data_out_q;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          imm_sel_d = bus.imm_sel;
          src_d     = bus.src;
          dst_d     = bus.dst;
          imm_d     = bus.imm;
          if (dst_bad || src_bad) begin
            state_d = StErr;
          end else if (is_noop) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = StWrite;
      StWrite: begin
        state_d    = StHold;
        data_out_d = bus.bus_in;
      end
      StHold:  state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      imm_sel_q  <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      imm_sel_q  <= imm_sel_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      imm_q      <= imm_d;
      data_out_q <= data_out_d;
    end
  end

  // Strobes decode straight from reset flops so an async reset drops them in the same timestep.
  assign src_drive = (state_q == StRead) || (state_q == StWrite) || (state_q == StHold);
  assign bus_oe    = src_drive && imm_sel_q;

  always_comb begin
    read_en  = '0;
    write_en = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      read_en[i]  = src_drive && !imm_sel_q && (src_q == IDX_W'(i));
      write_en[i] = (state_q == StWrite) && (dst_q == IDX_W'(i));
    end
  end

  assign bus.ready    = (state_q == StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.err      = (state_q == StErr);
  assign bus.read_en  = read_en;
  assign bus.write_en = write_en;
  assign bus.bus_oe   = bus_oe;
  assign bus.bus_out  = bus_oe ? imm_q : 16'h0000;
  assign bus.data_out = data_out_q;

`ifdef XFER_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if ((state_q == StDone) && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.xfer_count = xfer_count_q;
`endif

  a_read_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(read_en));
  a_write_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(write_en));
  a_no_contention: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus_oe && (read_en != '0)));
  // A destination may only latch after its source has had a full cycle on the bus.
  a_src_settled: assert property (@(posedge clk) disable iff (!reset_n)
    (write_en != '0) |-> $past(src_drive));

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: register-bank environment, transaction-level reference model,
// directed boundary cases and randomized requests. XFER_COUNT_EN adds counter checks.
module tb_reg_bus_ctrl;

  localparam int unsigned NREG  = 6;
  localparam int unsigned IDX_W = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_bus_ctrl_if #(.NREG(NREG), .IDX_W(IDX_W)) bif ();

  reg_bus_ctrl #(.NREG(NREG), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int checks = 0;
  int errors = 0;

  // Register bank on the shared bus, with a bench-side preload port.
  logic [15:0]      bank [NREG];
  logic             pre_we = 1'b0;
  logic [IDX_W-1:0] pre_idx = '0;
  logic [15:0]      pre_val = '0;

  always @(posedge clk) begin
    if (pre_we) bank[pre_idx] <= pre_val;
    for (int i = 0; i < NREG; i++) begin
      if (bif.write_en[i]) bank[i] <= bif.bus_in;
    end
  end

  always_comb begin
    bif.bus_in = 16'hDEAD;
    if (bif.bus_oe) bif.bus_in = bif.bus_out;
    for (int i = 0; i < NREG; i++) begin
      if (bif.read_en[i]) bif.bus_in = bank[i];
    end
  end

  // Reference model: a transfer is a kind plus a cycle offset since acceptance.
  typedef enum int {KErr, KNoop, KMove} kind_e;
  int               m_t = 0;
  int               m_fin = 0;
  kind_e            m_kind = KNoop;
  logic             m_imm_sel = 1'b0;
  logic [IDX_W-1:0] m_src = '0;
  logic [IDX_W-1:0] m_dst = '0;
  logic [15:0]      m_imm = '0;
  logic [15:0]      m_val = '0;
  logic [15:0]      m_data = '0;
  logic [15:0]      m_regs [NREG];
`ifdef XFER_COUNT_EN
  logic [15:0]      m_count = '0;
  logic             cnt_pre = 1'b0;
`endif

  wire in_bad  = (32'(bif.dst) >= NREG) || (!bif.imm_sel && (32'(bif.src) >= NREG));
  wire in_noop = !bif.imm_sel && (bif.src == bif.dst);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t    <= 0;
      m_fin  <= 0;
      m_kind <= KNoop;
      m_data <= '0;
`ifdef XFER_COUNT_EN
      m_count <= '0;
`endif
    end else begin
      if (pre_we) m_regs[pre_idx] <= pre_val;
      if (m_t != 0) begin
        if (m_kind == KMove && m_t == 2) begin
          m_regs[m_dst] <= m_val;
          m_data        <= m_val;
        end
        if (m_t == m_fin) begin
          m_t <= 0;
`ifdef XFER_COUNT_EN
          if (m_kind != KErr && m_count != 16'hFFFF) m_count <= m_count + 16'd1;
`endif
        end else begin
          m_t <= m_t + 1;
        end
      end else if (bif.req) begin
        m_imm_sel <= bif.imm_sel;
        m_src     <= bif.src;
        m_dst     <= bif.dst;
        m_imm     <= bif.imm;
        m_val     <= bif.imm_sel ? bif.imm : (in_bad ? 16'h0 : m_regs[bif.src]);
        m_kind    <= in_bad ? KErr : (in_noop ? KNoop : KMove);
        m_fin     <= (in_bad || in_noop) ? 1 : 4;
        m_t       <= 1;
      end
`ifdef XFER_COUNT_EN
      if (cnt_pre) m_count <= 16'hFFFE;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic            drv;
    logic [NREG-1:0] one;
    logic [NREG-1:0] e_rd;
    logic [NREG-1:0] e_wr;
    int              nbad;
    one  = 1;
    drv  = (m_kind == KMove) && (m_t >= 1) && (m_t <= 3);
    e_rd = (drv && !m_imm_sel) ? (one << m_src) : '0;
    e_wr = (m_kind == KMove && m_t == 2) ? (one << m_dst) : '0;
    chk("ready", bif.ready, m_t == 0);
    chk("done", bif.done, (m_t != 0) && (m_t == m_fin) && (m_kind != KErr));
    chk("err", bif.err, (m_t != 0) && (m_kind == KErr));
    chk("read_en", bif.read_en, e_rd);
    chk("write_en", bif.write_en, e_wr);
    chk("bus_oe", bif.bus_oe, drv && m_imm_sel);
    chk("bus_out", bif.bus_out, (drv && m_imm_sel) ? m_imm : 16'h0);
    chk("data_out", bif.data_out, m_data);
    nbad = 0;
    for (int i = 0; i < NREG; i++) begin
      if (bank[i] !== m_regs[i]) nbad++;
    end
    chk("bank", nbad, 0);
`ifdef XFER_COUNT_EN
    chk("xfer_count", bif.xfer_count, m_count);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    if (reset_n) model_check();
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [15:0] val);
    pre_we  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    tick();
    pre_we  = 1'b0;
  endtask

  // Present a request for one accept edge; fields are scrambled afterwards.
  task automatic issue(input logic is, input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d,
                       input logic [15:0] v);
    bif.req     = 1'b1;
    bif.imm_sel = is;
    bif.src     = s;
    bif.dst     = d;
    bif.imm     = v;
    tick();
    bif.req     = 1'b0;
    bif.imm_sel = 1'($urandom_range(0, 1));
    bif.src     = IDX_W'($urandom_range(0, 7));
    bif.dst     = IDX_W'($urandom_range(0, 7));
    bif.imm     = 16'($urandom);
  endtask

  initial begin
    int nd;
    bif.req = 1'b0; bif.imm_sel = 1'b0; bif.src = '0; bif.dst = '0; bif.imm = '0;

    tick(); tick();
    chk("rst ready", bif.ready, 1);
    chk("rst done", bif.done, 0);
    chk("rst err", bif.err, 0);
    chk("rst read_en", bif.read_en, 0);
    chk("rst write_en", bif.write_en, 0);
    chk("rst bus_oe", bif.bus_oe, 0);
    chk("rst bus_out", bif.bus_out, 0);
    chk("rst data_out", bif.data_out, 0);
    reset_n = 1'b1;

    for (int i = 0; i < NREG; i++) preload(IDX_W'(i), 16'($urandom));

    // Register to register: reg3 -> reg5.
    preload(3, 16'hFFF6);
    issue(0, 3, 5, 16'h0);
    chk("mv c1 read_en", bif.read_en, 6'h08);
    chk("mv c1 write_en", bif.write_en, 0);
    tick();
    chk("mv c2 read_en", bif.read_en, 6'h08);
    chk("mv c2 write_en", bif.write_en, 6'h20);
    tick();
    chk("mv c3 read_en", bif.read_en, 6'h08);
    chk("mv c3 write_en", bif.write_en, 0);
    tick();
    chk("mv c4 done", bif.done, 1);
    chk("mv c4 read_en", bif.read_en, 0);
    tick();
    chk("mv data_out", bif.data_out, 16'hFFF6);
    chk("mv reg5", bank[5], 16'hFFF6);

    // Immediate into reg0; src=7 must be ignored.
    issue(1, 7, 0, 16'h1234);
    chk("imm c1 bus_oe", bif.bus_oe, 1);
    chk("imm c1 bus_out", bif.bus_out, 16'h1234);
    chk("imm c1 read_en", bif.read_en, 0);
    tick();
    chk("imm c2 write_en", bif.write_en, 6'h01);
    chk("imm c2 bus_oe", bif.bus_oe, 1);
    tick();
    chk("imm c3 bus_oe", bif.bus_oe, 1);
    tick();
    chk("imm c4 done", bif.done, 1);
    tick();
    chk("imm data_out", bif.data_out, 16'h1234);
    chk("imm bus_out idle", bif.bus_out, 0);

    // No-op and rejected requests.
    issue(0, 2, 2, 16'h0);
    chk("noop c1 done", bif.done, 1);
    chk("noop c1 read_en", bif.read_en, 0);
    chk("noop c1 write_en", bif.write_en, 0);
    tick();
    chk("noop ready", bif.ready, 1);
    chk("noop data_out", bif.data_out, 16'h1234);
    issue(0, 1, 7, 16'h0);
    chk("errdst c1 err", bif.err, 1);
    chk("errdst c1 done", bif.done, 0);
    chk("errdst c1 write_en", bif.write_en, 0);
    tick();
    issue(0, 6, 1, 16'h0);
    chk("errsrc c1 err", bif.err, 1);
    chk("errsrc c1 read_en", bif.read_en, 0);
    tick();
    chk("err data_out", bif.data_out, 16'h1234);

    // req held high while busy yields exactly one transfer.
    bif.req = 1'b1; bif.imm_sel = 1'b1; bif.dst = 4; bif.imm = 16'hBEEF;
    nd = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      nd += int'(bif.done);
      if (k == 4) bif.req = 1'b0;
      else if (k < 4) bif.imm = 16'($urandom);
    end
    chk("held done count", nd, 1);
    chk("held data_out", bif.data_out, 16'hBEEF);

    // Reset during WRITE: strobes drop at once, reg4 untouched, next request works.
    preload(4, 16'h0A55);
    issue(0, 1, 4, 16'h0);
    tick();
    chk("abort pre write_en", bif.write_en, 6'h10);
    #1 reset_n = 1'b0;
    #1;
    chk("abort write_en", bif.write_en, 0);
    chk("abort read_en", bif.read_en, 0);
    chk("abort data_out", bif.data_out, 0);
    chk("abort ready", bif.ready, 1);
    #1 reset_n = 1'b1;
    tick();
    chk("abort reg4", bank[4], 16'h0A55);
    issue(0, 4, 1, 16'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("post abort data_out", bif.data_out, 16'h0A55);
    chk("post abort reg1", bank[1], 16'h0A55);

    // Randomized requests, inputs changing every cycle regardless of ready.
    for (int n = 0; n < 600; n++) begin
      tick();
      bif.req     = ($urandom_range(0, 3) != 0);
      bif.imm_sel = 1'($urandom_range(0, 1));
      bif.src     = IDX_W'($urandom_range(0, 7));
      bif.dst     = ($urandom_range(0, 7) == 0) ? bif.src : IDX_W'($urandom_range(0, 7));
      bif.imm     = 16'($urandom);
    end
    bif.req = 1'b0;
    for (int k = 0; k < 6; k++) tick();

`ifdef XFER_COUNT_EN
    force dut.xfer_count_q = 16'hFFFE;
    cnt_pre = 1'b1;
    tick();
    release dut.xfer_count_q;
    cnt_pre = 1'b0;
    tick();
    chk("cnt preload", bif.xfer_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      issue(0, 1, 1, 16'h0);
      tick();
    end
    chk("cnt saturate", bif.xfer_count, 16'hFFFF);
    issue(0, 0, 7, 16'h0);
    tick();
    chk("cnt after err", bif.xfer_count, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
